cordic_sweep_ctrl: RTL and testbench

- Upstream sequencer for the CORDIC top (start/mode/theta_deg -> result_out/done).
- Accepts one sweep job (start angle, step, count, mode) and issues one CORDIC operation per point.
- Collects each result into a small output FIFO with a valid/ready stream to downstream consumers.
- Angle arithmetic is Q16.16 signed degrees, matching the CORDIC top's theta_deg and result_out format.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_res_fifo.sv | 49 ++++
 rtl/cordic_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and Q16.16 angle helper for the CORDIC sweep controller.
// Optional watchdog in the top is enabled with CORDIC_TIMEOUT_EN.
package cordic_pkg;

   localparam int          DATA_W         = 32;
   localparam logic [31:0] DEG360_Q16     = 32'h0168_0000;
   localparam logic [31:0] NEG_DEG360_Q16 = 32'hFE98_0000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   // One-step wrap keeps the angle inside (-360, +360) for |step| < 360
   function automatic logic [31:0] theta_next(
      input logic [31:0] i_th,
      input logic [31:0] i_st
   );
      logic signed [32:0] t;
      t = $signed({i_th[31], i_th}) + $signed({i_st[31], i_st});
      if (t >= $signed({1'b0, DEG360_Q16}))
         t = t - $signed({1'b0, DEG360_Q16});
      else if (t <= $signed({1'b1, NEG_DEG360_Q16}))
         t = t + $signed({1'b0, DEG360_Q16});
      return t[31:0];
   endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// Synchronous result FIFO, power-of-two depth, register-array head output.
// Independent of CORDIC_TIMEOUT_EN.
module cordic_res_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_cnt;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_wr      = i_wr_en & ~o_full;
   assign w_rd      = i_rd_en & ~o_empty;
   assign o_rd_data = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         if (w_wr && !w_rd) r_cnt <= r_cnt + 1'b1;
         else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// Sweep sequencer: issues one CORDIC op per angle point and queues results.
// Define CORDIC_TIMEOUT_EN to enable the WAIT-state watchdog and sticky err.
module cordic_sweep_ctrl
   import cordic_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [31:0]      cfg_theta_start,
   input  logic [31:0]      cfg_theta_step,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             cfg_mode,
   output logic             cor_start,
   output logic             cor_mode,
   output logic [31:0]      cor_theta,
   input  logic [31:0]      cor_result,
   input  logic             cor_done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [CNT_W-1:0] res_index,
   output logic             res_last,
   output logic             busy,
   output logic             err
);

   localparam int FW = DATA_W + CNT_W + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT_CYC < 2) begin : g_bad_param
      $error("cordic_sweep_ctrl: bad parameter");
   end

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_theta;
   logic [31:0]      r_step;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_idx;
   logic             r_mode;
   logic             r_done_q;
   logic             r_hold;
   logic             w_full;
   logic             w_empty;
   logic             w_edge;
   logic             w_last;
   logic             w_accept;
   logic             w_wr;
   logic             w_tmo;
   logic [FW-1:0]    w_rd_data;

   assign w_accept  = cfg_valid & (r_state == IDLE);
   assign w_edge    = cor_done & ~r_done_q & (r_state == WAIT);
   assign w_last    = (r_idx == r_count - 1'b1);
   assign cfg_ready = (r_state == IDLE);
   assign cor_theta = r_theta;
   assign cor_mode  = r_mode;
   assign res_valid = ~w_empty;
   assign busy      = (r_state != IDLE) | ~w_empty;

`ifdef CORDIC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_tmo;
   logic          r_err;

   assign w_tmo = (r_state == WAIT) & ~w_edge &
                  (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign err   = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         r_tmo <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
         if (w_tmo) r_err <= 1'b1;
      end
   end
`else
   assign w_tmo = 1'b0;
   assign err   = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      cor_start = 1'b0;
      w_wr      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept && cfg_count != '0) w_next = ISSUE;
         end
         ISSUE: begin
            // r_hold spaces the next start two cycles after a done edge
            if (!w_full && !r_hold) begin
               cor_start = 1'b1;
               w_next    = WAIT;
            end
         end
         WAIT: begin
            if (w_edge) begin
               w_wr   = 1'b1;
               w_next = w_last ? IDLE : ISSUE;
            end else if (w_tmo) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_theta  <= '0;
         r_step   <= '0;
         r_count  <= '0;
         r_idx    <= '0;
         r_mode   <= 1'b0;
         r_done_q <= 1'b0;
         r_hold   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_done_q <= cor_done;
         r_hold   <= w_edge;
         if (w_accept) begin
            r_theta <= cfg_theta_start;
            r_step  <= cfg_theta_step;
            r_count <= cfg_count;
            r_mode  <= cfg_mode;
            r_idx   <= '0;
         end
         if (w_wr) begin
            r_theta <= theta_next(r_theta, r_step);
            r_idx   <= r_idx + 1'b1;
         end
      end
   end

   cordic_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr),
      .i_wr_data ({cor_result, r_idx, w_last}),
      .i_rd_en   (res_ready),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign {res_data, res_index, res_last} = w_rd_data;

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Randomised bench for cordic_sweep_ctrl with a behavioural CORDIC and sweep model.
// Timeout scenario runs only when CORDIC_TIMEOUT_EN is defined.
module tb_cordic_sweep_ctrl;

   localparam int CNT_W = 16;
   localparam int DEPTH = 4;
   localparam int RW    = 32 + CNT_W + 1;
   localparam longint Q360 = 64'sd23592960;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [31:0]      cfg_theta_start;
   logic [31:0]      cfg_theta_step;
   logic [CNT_W-1:0] cfg_count;
   logic             cfg_mode;
   logic             cor_start;
   logic             cor_mode;
   logic [31:0]      cor_theta;
   logic [31:0]      cor_result;
   logic             cor_done;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [CNT_W-1:0] res_index;
   logic             res_last;
   logic             busy;
   logic             err;

   int checks   = 0;
   int failures = 0;

   int  cyc       = 0;
   int  last_done = -100;
   int  gap_bad   = 0;
   int  lat_fixed = 0;
   bit  hang      = 0;
   bit  late_req  = 0;
   bit  rr_rand   = 0;
   bit  rr_fixed  = 1;
   int  cd        = 0;
   logic [31:0] pend = '0;

   logic [32:0]   st_q[$];
   logic [RW-1:0] rs_q[$];
   logic [32:0]   exp_st[$];
   logic [RW-1:0] exp_rs[$];

   cordic_sweep_ctrl #(
      .CNT_W       (CNT_W),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_theta_start (cfg_theta_start),
      .cfg_theta_step  (cfg_theta_step),
      .cfg_count       (cfg_count),
      .cfg_mode        (cfg_mode),
      .cor_start       (cor_start),
      .cor_mode        (cor_mode),
      .cor_theta       (cor_theta),
      .cor_result      (cor_result),
      .cor_done        (cor_done),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_data        (res_data),
      .res_index       (res_index),
      .res_last        (res_last),
      .busy            (busy),
      .err             (err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] res_of(input logic [31:0] th, input logic m);
      return {th[15:0], th[31:16]} ^ {32{m}} ^ 32'h5A5A_0000;
   endfunction

   // Behavioural CORDIC: done pulses lat cycles after a sampled start
   initial begin
      cor_done   = 1'b0;
      cor_result = '0;
      forever begin
         @(negedge clk);
         if (cor_start && !hang) begin
            cd   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
            pend = res_of(cor_theta, cor_mode);
         end
         @(posedge clk);
         #1;
         if (!rst_n) cd = 0;
         cor_done = late_req;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               cor_done   = 1'b1;
               cor_result = pend;
            end
         end
      end
   end

   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (cor_done) last_done = cyc;
      if (cor_start) begin
         if (cyc - last_done < 2) gap_bad++;
         st_q.push_back({cor_mode, cor_theta});
      end
      if (res_valid && res_ready)
         rs_q.push_back({res_data, res_index, res_last});
   end

   task automatic build_exp(input logic [31:0] s, input logic [31:0] st,
                            input int n, input logic m);
      longint th;
      logic [31:0] t32;
      exp_st.delete();
      exp_rs.delete();
      th = longint'($signed(s));
      for (int i = 0; i < n; i++) begin
         t32 = th[31:0];
         exp_st.push_back({m, t32});
         exp_rs.push_back({res_of(t32, m), CNT_W'(i), (i == n - 1)});
         th = th + longint'($signed(st));
         if (th >= Q360) th = th - Q360;
         else if (th <= -Q360) th = th + Q360;
         t32 = th[31:0];
         th = longint'($signed(t32));
      end
   endtask

   task automatic send_cfg(input logic [31:0] s, input logic [31:0] st,
                           input int n, input logic m);
      @(posedge clk);
      #1;
      cfg_theta_start = s;
      cfg_theta_step  = st;
      cfg_count       = CNT_W'(n);
      cfg_mode        = m;
      cfg_valid       = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(cfg_ready && !busy) && k < lim);
      checks++;
      if (!(cfg_ready && !busy)) begin
         failures++;
         $display("FAIL %s_idle_timeout got busy=%b ready=%b want idle", tag, busy, cfg_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cfg_ready, cor_start, cor_mode, cor_theta, res_valid, res_data,
           res_index, res_last, busy, err} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
           32'h0, CNT_W'(0), 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_vals got ready=%b start=%b theta=%h valid=%b busy=%b err=%b want 1/0/0/0/0/0",
                  cfg_ready, cor_start, cor_theta, res_valid, busy, err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got ready=%b busy=%b want 1 0", cfg_ready, busy);
      end
   endtask

   task automatic test_sweeps();
      logic [31:0] s_tab[$];
      logic [31:0] st_tab[$];
      int          n_tab[$];
      logic        m_tab[$];
      int          bad;
      s_tab  = '{32'h0000_0000, 32'h015E_0000, 32'hFEA2_0000};
      st_tab = '{32'h001E_0000, 32'h0014_0000, 32'hFFEC_0000};
      n_tab  = '{4, 3, 3};
      m_tab  = '{1'b1, 1'b0, 1'b1};
      for (int r = 0; r < 8; r++) begin
         s_tab.push_back(32'(int'($urandom_range(0, 47185918)) - 23592959));
         st_tab.push_back(32'(int'($urandom_range(0, 47185918)) - 23592959));
         n_tab.push_back(int'($urandom_range(1, 7)));
         m_tab.push_back(1'($urandom_range(0, 1)));
      end
      foreach (s_tab[j]) begin
         rr_rand = (j >= 3);
         build_exp(s_tab[j], st_tab[j], n_tab[j], m_tab[j]);
         st_q.delete();
         rs_q.delete();
         send_cfg(s_tab[j], st_tab[j], n_tab[j], m_tab[j]);
         @(negedge clk);
         checks++;
         if (cor_start !== 1'b1) begin
            failures++;
            $display("FAIL sweep%0d_first_start got=%b want=1", j, cor_start);
         end
         wait_idle($sformatf("sweep%0d", j), 2000);
         bad = 0;
         foreach (exp_st[i]) if (i >= st_q.size() || st_q[i] !== exp_st[i]) bad++;
         checks++;
         if (st_q.size() != exp_st.size() || bad != 0) begin
            failures++;
            $display("FAIL sweep%0d_theta got n=%0d first=%h want n=%0d first=%h bad=%0d",
                     j, st_q.size(), (st_q.size() > 0) ? st_q[0] : 33'h0, exp_st.size(), exp_st[0], bad);
         end
         bad = 0;
         foreach (exp_rs[i]) if (i >= rs_q.size() || rs_q[i] !== exp_rs[i]) bad++;
         checks++;
         if (rs_q.size() != exp_rs.size() || bad != 0) begin
            failures++;
            $display("FAIL sweep%0d_results got n=%0d want n=%0d bad=%0d",
                     j, rs_q.size(), exp_rs.size(), bad);
         end
      end
      rr_rand = 0;
      checks++;
      if (gap_bad != 0) begin
         failures++;
         $display("FAIL start_gap got violations=%0d want=0", gap_bad);
      end
   endtask

   task automatic test_zero_and_ignore();
      int bad;
      st_q.delete();
      rs_q.delete();
      send_cfg(32'h0010_0000, 32'h0001_0000, 0, 1'b1);
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_count_ready got ready=%b busy=%b want 1 0", cfg_ready, busy);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (st_q.size() != 0) begin
         failures++;
         $display("FAIL zero_count_starts got=%0d want=0", st_q.size());
      end
      lat_fixed = 6;
      build_exp(32'h0005_0000, 32'h0002_0000, 2, 1'b0);
      send_cfg(32'h0005_0000, 32'h0002_0000, 2, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      cfg_theta_start = 32'h00AA_0000;
      cfg_count       = CNT_W'(5);
      cfg_mode        = 1'b1;
      cfg_valid       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      wait_idle("ignore", 500);
      bad = 0;
      foreach (exp_st[i]) if (i >= st_q.size() || st_q[i] !== exp_st[i]) bad++;
      foreach (exp_rs[i]) if (i >= rs_q.size() || rs_q[i] !== exp_rs[i]) bad++;
      checks++;
      if (st_q.size() != 2 || rs_q.size() != 2 || bad != 0) begin
         failures++;
         $display("FAIL busy_ignore got starts=%0d results=%0d bad=%0d want 2 2 0",
                  st_q.size(), rs_q.size(), bad);
      end
      lat_fixed = 0;
   endtask

   task automatic test_backpressure();
      int k;
      int bad;
      rr_fixed = 0;
      repeat (2) @(posedge clk);
      build_exp(32'h0001_8000, 32'h002D_0000, 6, 1'b1);
      st_q.delete();
      rs_q.delete();
      send_cfg(32'h0001_8000, 32'h002D_0000, 6, 1'b1);
      k = 0;
      while (st_q.size() < 4 && k < 200) begin
         @(negedge clk);
         k++;
      end
      repeat (60) @(negedge clk);
      checks++;
      if (st_q.size() != DEPTH || res_valid !== 1'b1 || rs_q.size() != 0) begin
         failures++;
         $display("FAIL bp_stall got starts=%0d valid=%b out=%0d want 4 1 0",
                  st_q.size(), res_valid, rs_q.size());
      end
      rr_fixed = 1;
      wait_idle("bp", 1000);
      bad = 0;
      foreach (exp_st[i]) if (i >= st_q.size() || st_q[i] !== exp_st[i]) bad++;
      foreach (exp_rs[i]) if (i >= rs_q.size() || rs_q[i] !== exp_rs[i]) bad++;
      checks++;
      if (st_q.size() != 6 || rs_q.size() != 6 || bad != 0) begin
         failures++;
         $display("FAIL bp_drain got starts=%0d results=%0d bad=%0d want 6 6 0",
                  st_q.size(), rs_q.size(), bad);
      end
   endtask

   task automatic test_reset_midjob();
      int k;
      int nres;
      lat_fixed = 30;
      st_q.delete();
      rs_q.delete();
      send_cfg(32'h0000_0000, 32'h000A_0000, 4, 1'b0);
      k = 0;
      while (st_q.size() < 3 && k < 300) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (st_q.size() != 3) begin
         failures++;
         $display("FAIL midjob_reach got starts=%0d want=3", st_q.size());
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cfg_ready, cor_start, cor_theta, cor_mode, res_valid, res_index, busy} !==
          {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, CNT_W'(0), 1'b0}) begin
         failures++;
         $display("FAIL midjob_reset got ready=%b start=%b theta=%h valid=%b busy=%b want 1 0 0 0 0",
                  cfg_ready, cor_start, cor_theta, res_valid, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nres = rs_q.size();
      repeat (2) @(posedge clk);
      #1;
      late_req = 1'b1;
      @(posedge clk);
      #1;
      late_req = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (st_q.size() != 3 || rs_q.size() != nres || res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midjob_late_done got starts=%0d results=%0d valid=%b want 3 %0d 0",
                  st_q.size(), rs_q.size(), res_valid, nres);
      end
      lat_fixed = 0;
   endtask

   task automatic test_timeout();
`ifdef CORDIC_TIMEOUT_EN
      int k;
      hang = 1;
      st_q.delete();
      rs_q.delete();
      send_cfg(32'h0000_0000, 32'h0001_0000, 3, 1'b0);
      @(negedge clk);
      k = 0;
      while (err !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != 17) begin
         failures++;
         $display("FAIL timeout_cycles got=%0d want=17", k);
      end
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1 || st_q.size() != 1 || rs_q.size() != 0 || err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_abort got ready=%b starts=%0d results=%0d err=%b want 1 1 0 1",
                  cfg_ready, st_q.size(), rs_q.size(), err);
      end
      hang = 0;
`else
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_tied got=%b want=0", err);
      end
`endif
   endtask

   initial begin
      cfg_valid       = 1'b0;
      cfg_theta_start = '0;
      cfg_theta_step  = '0;
      cfg_count       = '0;
      cfg_mode        = 1'b0;
      test_reset();
      test_sweeps();
      test_zero_and_ignore();
      test_backpressure();
      test_reset_midjob();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
